// File: rtl/ifetch_queue.sv
// Instruction fetch unit: one outstanding memory read feeding a small in-order prefetch queue for ID.
// Optional feature macro IFQ_BYPASS_EN: forward an acked word straight to ID when the queue is empty.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc4,
    input  logic        out_ready
);

    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   entry_q [DEPTH];

    logic        not_empty;
    logic        ack_ok;
    logic        bypass;
    logic        enq;
    logic        deq;
    logic [31:0] next_pc;
    logic [63:0] head;

    // Queue control: redirect wins over any same-cycle ack or pop.
    always_comb begin
        next_pc   = fetch_pc_q + 32'd4;
        not_empty = (count_q != '0);
        ack_ok    = (state_q == WAIT) && mem_ack && !redirect;
`ifdef IFQ_BYPASS_EN
        bypass    = ack_ok && !not_empty;
`else
        bypass    = 1'b0;
`endif
        enq       = ack_ok && !(bypass && out_ready);
        deq       = not_empty && out_ready && !redirect;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Fetch FSM; issue only from IDLE, so occupancy alone bounds the queue.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = {redirect_pc[31:2], 2'b00};
                end else if (count_q < FULL) begin
                    state_d    = WAIT;
                    req_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = {redirect_pc[31:2], 2'b00};
                    state_d    = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    fetch_pc_d = next_pc;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = {redirect_pc[31:2], 2'b00};
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_q[wr_ptr_q] <= {mem_rdata, next_pc};
        end
    end

    assign head      = entry_q[rd_ptr_q];
    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = req_addr_q;
    assign out_valid = not_empty || bypass;

    always_comb begin
        out_inst = 32'd0;
        out_pc4  = 32'd0;
        if (not_empty) begin
            out_inst = head[63:32];
            out_pc4  = head[31:0];
        end else if (bypass) begin
            out_inst = mem_rdata;
            out_pc4  = next_pc;
        end
    end

endmodule
